// File: rtl/wb_queue_if.sv
// Handshake, write-port and hazard-lookup signals of the write-back queue.
// master = producers/register-file side, slave = the queue itself.
interface wb_queue_if;
  logic        mem_valid;
  logic [2:0]  mem_addr;
  logic [15:0] mem_data;
  logic        mem_ready;
  logic        alu_valid;
  logic [2:0]  alu_addr;
  logic [15:0] alu_data;
  logic        alu_ready;
  logic        write_back;
  logic [2:0]  write_addr;
  logic [15:0] write_data;
  logic [2:0]  rd_addr1;
  logic [2:0]  rd_addr2;
  logic        hit1;
  logic        hit2;
  logic [15:0] fwd_data1;
  logic [15:0] fwd_data2;

  modport master (
    output mem_valid, mem_addr, mem_data, alu_valid, alu_addr, alu_data,
           rd_addr1, rd_addr2,
    input  mem_ready, alu_ready, write_back, write_addr, write_data,
           hit1, hit2, fwd_data1, fwd_data2
  );

  modport slave (
    input  mem_valid, mem_addr, mem_data, alu_valid, alu_addr, alu_data,
           rd_addr1, rd_addr2,
    output mem_ready, alu_ready, write_back, write_addr, write_data,
           hit1, hit2, fwd_data1, fwd_data2
  );
endinterface

// File: rtl/wb_queue.sv
// In-order write-back FIFO owning the register-file write port, with RAW hazard lookup.
// Define WB_FORWARD_EN to build the youngest-match forwarding data path.
module wb_queue #(
  parameter int DEPTH = 4
) (
  input logic       clk,
  input logic       rst_n,
  wb_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    addr_q [DEPTH];
  logic [2:0]    addr_d [DEPTH];
  logic [15:0]   data_q [DEPTH];
  logic [15:0]   data_d [DEPTH];

  logic          mem_acc, alu_acc, pop;
  logic [AW-1:0] alu_slot;
  logic [DEPTH-1:0] occ, match1, match2;

  // Ready looks only at the registered count; a pop in the same cycle gives no credit.
  assign bus.mem_ready = (count_q <= CW'(DEPTH - 1));
  assign bus.alu_ready = (count_q <= CW'(DEPTH - 2));
  assign mem_acc = bus.mem_valid && bus.mem_ready;
  assign alu_acc = bus.alu_valid && bus.alu_ready;
  assign pop     = (count_q != '0);

  always_comb begin
    head_d   = head_q + AW'(pop);
    tail_d   = tail_q + AW'(mem_acc) + AW'(alu_acc);
    count_d  = count_q + CW'(mem_acc) + CW'(alu_acc) - CW'(pop);
    alu_slot = tail_q + AW'(mem_acc);
    for (int i = 0; i < DEPTH; i++) begin
      addr_d[i] = addr_q[i];
      data_d[i] = data_q[i];
    end
    // Mem is the older of a same-cycle pair, so it takes the tail slot.
    if (mem_acc) begin
      addr_d[tail_q] = bus.mem_addr;
      data_d[tail_q] = bus.mem_data;
    end
    if (alu_acc) begin
      addr_d[alu_slot] = bus.alu_addr;
      data_d[alu_slot] = bus.alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
    addr_q <= addr_d;
    data_q <= data_d;
  end

  // A slot is occupied when its distance from head is below count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [AW-1:0] age;
    assign age         = AW'(gi) - head_q;
    assign occ[gi]     = ({1'b0, age} < count_q);
    assign match1[gi]  = occ[gi] && (addr_q[gi] == bus.rd_addr1);
    assign match2[gi]  = occ[gi] && (addr_q[gi] == bus.rd_addr2);
  end

  assign bus.write_back = pop;
  assign bus.write_addr = pop ? addr_q[head_q] : 3'd0;
  assign bus.write_data = pop ? data_q[head_q] : 16'd0;
  assign bus.hit1       = |match1;
  assign bus.hit2       = |match2;

`ifdef WB_FORWARD_EN
  logic [15:0]   fwd1, fwd2;
  logic [AW-1:0] idx;

  // Walk from oldest to youngest so the last match wins.
  always_comb begin
    fwd1 = '0;
    fwd2 = '0;
    idx  = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + AW'(k);
      if (match1[idx]) fwd1 = data_q[idx];
      if (match2[idx]) fwd2 = data_q[idx];
    end
  end

  assign bus.fwd_data1 = fwd1;
  assign bus.fwd_data2 = fwd2;
`else
  assign bus.fwd_data1 = '0;
  assign bus.fwd_data2 = '0;
`endif
endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed scenarios plus randomized streams
// checked against a queue-based reference model.
module tb_wb_queue;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

`ifdef WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  always #5 clk = ~clk;

  wb_queue_if bus ();

  wb_queue #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic idle_inputs();
    bus.mem_valid = 1'b0;
    bus.mem_addr  = 3'd0;
    bus.mem_data  = 16'd0;
    bus.alu_valid = 1'b0;
    bus.alu_addr  = 3'd0;
    bus.alu_data  = 16'd0;
    bus.rd_addr1  = 3'd0;
    bus.rd_addr2  = 3'd0;
  endtask

  task automatic test_reset();
    logic [55:0] got, exp;
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    got = {bus.write_back, bus.write_addr, bus.write_data, bus.hit1, bus.hit2,
           bus.fwd_data1, bus.fwd_data2, bus.mem_ready, bus.alu_ready};
    exp = {1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1, 1'b1};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL reset_outputs got=%h required=%h", got, exp);
    end
    $display("reset released");
  endtask

  task automatic test_single_write();
    @(negedge clk);
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 3'd3;
    bus.alu_data  = 16'h1234;
    bus.rd_addr1  = 3'd3;
    #1;
    checks++;
    if (bus.alu_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_alu_ready got=%b required=1", bus.alu_ready);
    end
    @(posedge clk);
    #1;
    bus.alu_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.write_back, bus.write_addr, bus.write_data} !== {1'b1, 3'd3, 16'h1234}) begin
      failures++;
      $display("FAIL single_write got=%b/%0d/%h required=1/3/1234",
               bus.write_back, bus.write_addr, bus.write_data);
    end
    checks++;
    if (bus.hit1 !== 1'b1) begin
      failures++;
      $display("FAIL single_hit1 got=%b required=1", bus.hit1);
    end
    $display("single write r3=1234 retired");
    @(negedge clk);
    checks++;
    if ({bus.write_back, bus.hit1} !== 2'b00) begin
      failures++;
      $display("FAIL single_drained got wb=%b hit1=%b required 0/0", bus.write_back, bus.hit1);
    end
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    bus.mem_valid = 1'b1; bus.mem_addr = 3'd1; bus.mem_data = 16'hAAAA;
    bus.alu_valid = 1'b1; bus.alu_addr = 3'd2; bus.alu_data = 16'h5555;
    @(posedge clk);
    #1;
    bus.mem_valid = 1'b0;
    bus.alu_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.write_back, bus.write_addr, bus.write_data} !== {1'b1, 3'd1, 16'hAAAA}) begin
      failures++;
      $display("FAIL simul_first got=%b/%0d/%h required=1/1/aaaa",
               bus.write_back, bus.write_addr, bus.write_data);
    end
    @(negedge clk);
    checks++;
    if ({bus.write_back, bus.write_addr, bus.write_data} !== {1'b1, 3'd2, 16'h5555}) begin
      failures++;
      $display("FAIL simul_second got=%b/%0d/%h required=1/2/5555",
               bus.write_back, bus.write_addr, bus.write_data);
    end
    $display("simultaneous r1=aaaa r2=5555 retired");
    @(negedge clk);
    checks++;
    if (bus.write_back !== 1'b0) begin
      failures++;
      $display("FAIL simul_drained got wb=%b required=0", bus.write_back);
    end
  endtask

  task automatic test_forwarding();
    logic [15:0] exp1;
    @(negedge clk);
    bus.mem_valid = 1'b1; bus.mem_addr = 3'd5; bus.mem_data = 16'h0001;
    bus.alu_valid = 1'b1; bus.alu_addr = 3'd5; bus.alu_data = 16'h0002;
    bus.rd_addr1 = 3'd5;
    bus.rd_addr2 = 3'd6;
    @(posedge clk);
    #1;
    bus.mem_valid = 1'b0;
    bus.alu_valid = 1'b0;
    exp1 = FWD ? 16'h0002 : 16'h0000;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.hit1, bus.fwd_data1} !== {1'b1, exp1}) begin
        failures++;
        $display("FAIL fwd_port1 cyc=%0d got=%b/%h required=1/%h", c, bus.hit1, bus.fwd_data1, exp1);
      end
      checks++;
      if ({bus.hit2, bus.fwd_data2} !== {1'b0, 16'h0000}) begin
        failures++;
        $display("FAIL fwd_port2 cyc=%0d got=%b/%h required=0/0000", c, bus.hit2, bus.fwd_data2);
      end
    end
    $display("forwarding r5 youngest=%h", exp1);
    @(negedge clk);
    checks++;
    if ({bus.hit1, bus.fwd_data1} !== {1'b0, 16'h0000}) begin
      failures++;
      $display("FAIL fwd_empty got=%b/%h required=0/0000", bus.hit1, bus.fwd_data1);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.mem_valid = 1'b1; bus.mem_addr = 3'd1; bus.mem_data = 16'h0011;
    bus.alu_valid = 1'b1; bus.alu_addr = 3'd2; bus.alu_data = 16'h0022;
    @(posedge clk);
    #1;
    bus.mem_addr = 3'd3; bus.mem_data = 16'h0033;
    bus.alu_addr = 3'd4; bus.alu_data = 16'h0044;
    @(posedge clk);
    #1;
    bus.mem_valid = 1'b0;
    bus.alu_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.mem_ready, bus.alu_ready} !== 2'b10) begin
      failures++;
      $display("FAIL midrst_three_queued got mr/ar=%b%b required=10", bus.mem_ready, bus.alu_ready);
    end
    rst_n = 1'b0;
    bus.mem_valid = 1'b1; bus.mem_addr = 3'd6; bus.mem_data = 16'h0066;
    bus.rd_addr1 = 3'd3;
    bus.rd_addr2 = 3'd4;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.mem_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.write_back, bus.hit1, bus.hit2} !== 3'b000) begin
        failures++;
        $display("FAIL midrst_flushed cyc=%0d got wb/h1/h2=%b%b%b required=000",
                 c, bus.write_back, bus.hit1, bus.hit2);
      end
    end
    $display("mid-operation reset flushed");
  endtask

  // Producers hold their offer until accepted; the model is a plain in-order queue.
  task automatic test_stream(input int n, input bit all_valid, input string name);
    logic [18:0] mq[$];
    bit          mp, ap, em_ready, ea_ready, eh1, eh2;
    logic [2:0]  ma, aa, ewa;
    logic [15:0] md, ad, ewd, ef1, ef2;
    int          cyc, alu_low;
    mp = 1'b0; ap = 1'b0; cyc = 0; alu_low = 0;
    mq.delete();
    while (cyc < n || mp || ap || mq.size() != 0) begin
      if (cyc > n + 40) begin
        failures++;
        $display("FAIL %s_drain_timeout queued=%0d required=0", name, mq.size());
        break;
      end
      @(negedge clk);
      if (!mp && cyc < n) begin
        mp = all_valid ? 1'b1 : ($urandom_range(0, 1) == 1);
        ma = 3'($urandom); md = 16'($urandom);
      end
      if (!ap && cyc < n) begin
        ap = all_valid ? 1'b1 : ($urandom_range(0, 2) != 0);
        aa = 3'($urandom); ad = 16'($urandom);
      end
      bus.mem_valid = mp; bus.mem_addr = ma; bus.mem_data = md;
      bus.alu_valid = ap; bus.alu_addr = aa; bus.alu_data = ad;
      bus.rd_addr1 = 3'($urandom);
      bus.rd_addr2 = 3'($urandom);
      #1;
      em_ready = (mq.size() <= 3);
      ea_ready = (mq.size() <= 2);
      ewa = 3'd0; ewd = 16'd0;
      if (mq.size() != 0) {ewa, ewd} = mq[0];
      eh1 = 1'b0; eh2 = 1'b0; ef1 = 16'd0; ef2 = 16'd0;
      foreach (mq[k]) begin
        if (mq[k][18:16] == bus.rd_addr1) begin eh1 = 1'b1; if (FWD) ef1 = mq[k][15:0]; end
        if (mq[k][18:16] == bus.rd_addr2) begin eh2 = 1'b1; if (FWD) ef2 = mq[k][15:0]; end
      end
      checks++;
      if ({bus.mem_ready, bus.alu_ready} !== {em_ready, ea_ready}) begin
        failures++;
        $display("FAIL %s_ready cyc=%0d got=%b%b required=%b%b", name, cyc,
                 bus.mem_ready, bus.alu_ready, em_ready, ea_ready);
      end
      checks++;
      if ({bus.write_back, bus.write_addr, bus.write_data} !== {mq.size() != 0, ewa, ewd}) begin
        failures++;
        $display("FAIL %s_write cyc=%0d got=%b/%0d/%h required=%b/%0d/%h", name, cyc,
                 bus.write_back, bus.write_addr, bus.write_data, mq.size() != 0, ewa, ewd);
      end
      checks++;
      if ({bus.hit1, bus.hit2, bus.fwd_data1, bus.fwd_data2} !== {eh1, eh2, ef1, ef2}) begin
        failures++;
        $display("FAIL %s_lookup cyc=%0d got=%b%b/%h/%h required=%b%b/%h/%h", name, cyc,
                 bus.hit1, bus.hit2, bus.fwd_data1, bus.fwd_data2, eh1, eh2, ef1, ef2);
      end
      if (!ea_ready) alu_low++;
      @(posedge clk);
      if (mq.size() != 0) void'(mq.pop_front());
      if (mp && em_ready) begin
        mq.push_back({ma, md});
        $display("xfer %s mem r%0d=%h", name, ma, md);
        mp = 1'b0;
      end
      if (ap && ea_ready) begin
        mq.push_back({aa, ad});
        $display("xfer %s alu r%0d=%h", name, aa, ad);
        ap = 1'b0;
      end
      cyc++;
    end
    idle_inputs();
    if (all_valid) begin
      checks++;
      if (alu_low == 0) begin
        failures++;
        $display("FAIL %s_alu_backpressure got low_cycles=0 required>0", name);
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_write();
    test_simultaneous();
    test_forwarding();
    test_stream(12, 1'b1, "backpressure");
    test_reset_mid();
    test_stream(300, 1'b0, "random");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_queue.md
# wb_queue

Write-back queue that owns the register file's single write port (`write_back`, `write_addr`, `write_data`). It sits between the ALU and memory result paths and the register file, and accepts up to two results per cycle through valid/ready handshakes. Results are buffered in order in a small FIFO and retired one per cycle. It also reports read-after-write hazards, with optional forwarding data, for the two register-file read addresses.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: synchronous active-low reset.
- `mem_valid`  in  1: memory/load result valid.
- `mem_addr`  in  3: destination register of memory result.
- `mem_data`  in  16: memory result data.
- `mem_ready`  out  1: memory result accepted this cycle if valid.
- `alu_valid`  in  1: ALU result valid.
- `alu_addr`  in  3: destination register of ALU result.
- `alu_data`  in  16: ALU result data.
- `alu_ready`  out  1: ALU result accepted this cycle if valid.
- `write_back`  out  1: register file write enable.
- `write_addr`  out  3: register file write address.
- `write_data`  out  16: register file write data.
- `rd_addr1`, `rd_addr2`  in  3 each: addresses currently read from the register file (dst, src).
- `hit1`, `hit2`  out  1 each: a pending write targets `rd_addrN`.
- `fwd_data1`, `fwd_data2`  out  16 each: data of the youngest pending write to `rd_addrN`.

## Operation
- **Storage.** Circular FIFO of `DEPTH` entries `{addr[2:0], data[15:0]}`. `head` and `tail` pointers are log2(DEPTH) bits and wrap modulo `DEPTH`. `count` is log2(DEPTH)+1 bits.
- **Ready.** Computed from registered `count` only; a same-cycle pop gives no credit.
  - `mem_ready = (count <= DEPTH-1)`
  - `alu_ready = (count <= DEPTH-2)`
- **Transfer.** A result transfers when `valid && ready`. A producer must hold valid, addr, and data stable until it transfers.
- **Enqueue order.** If both transfer in one cycle, the mem entry is written at `tail` and the ALU entry at `tail+1`, so the mem result is treated as older. If only one transfers, it is written at `tail`. `tail` advances by the number accepted.
- **Retire.**
  - `write_back = (count != 0)`.
  - `write_addr`/`write_data` come from the head entry, and are 0 when empty.
  - The register file always accepts, so the head pops at every rising edge where `count != 0`.
- **Count update.** `count_next = count + accepted − popped`. A simultaneous push and pop on a full queue is legal.
- **Hazard lookup.** Combinational over all occupied entries, including the head being written this cycle.
  - `hitN` is high if any occupied entry's addr equals `rd_addrN`.
  - Results being presented on the producer ports this cycle are not included.
- **Register 0.** No special handling; all 8 registers are writable and hazard-checked.
- **Invariants.** Never overflow or underflow, given the ready rules.

## Timing
- **Reset** (`rst_n` = 0 at a rising edge):
  - `head`, `tail`, `count` are cleared to 0, and FIFO contents are don't-care.
  - Outputs after reset: `write_back`=0, `write_addr`=0, `write_data`=0, `hit1`/`hit2`=0, `fwd_data1`/`fwd_data2`=0, `mem_ready`=1, `alu_ready`=1.
  - A reset mid-operation discards all pending entries. Handshakes presented in the reset cycle are not accepted.
- **Latency.**
  - A result accepted at edge N appears on the write port during cycle N+1 if the queue was empty, and is written into the register file at edge N+1.
  - Each older entry ahead of it adds one cycle.
- **Throughput.** One retire per cycle; sustained input above one result per cycle backs up to the ready limits.
- **Lookup.** `hitN` and `fwd_dataN` are valid in the same cycle as `rd_addrN` and the queue state, with no registered delay.

## Configuration
- **`WB_FORWARD_EN` defined:**
  - `fwd_dataN` is the data of the youngest occupied entry matching `rd_addrN`, searched from `tail−1` back to `head`.
  - `fwd_dataN` is 0 when `hitN`=0.
- **`WB_FORWARD_EN` undefined:**
  - `fwd_data1`/`fwd_data2` are tied to 0 and no data-select logic is built.
  - `hit1`/`hit2` behave identically; the consumer must stall on a hit.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles, then release. Required: all outputs at their reset values, `mem_ready`=`alu_ready`=1.
- **Single write:** ALU valid with addr=3, data=16'h1234 for one cycle into an empty queue. Required: next cycle `write_back`=1, `write_addr`=3, `write_data`=16'h1234; the cycle after, `write_back`=0.
- **Simultaneous inputs:** mem (addr 1, 16'hAAAA) and ALU (addr 2, 16'h5555) in the same cycle. Required: write port shows r1/AAAA, then r2/5555 on consecutive cycles.
- **Backpressure, DEPTH=4:** ALU valid continuously with mem valid continuously. Required:
  - `alu_ready` drops to 0 when `count` ≥ 3 and `mem_ready` drops to 0 when `count` = 4.
  - No result is lost or duplicated; write order equals accept order.
- **Forwarding, with `WB_FORWARD_EN`:** queue r5=16'h0001, then r5=16'h0002; `rd_addr1`=5, `rd_addr2`=6. Required: `hit1`=1, `fwd_data1`=16'h0002, `hit2`=0, `fwd_data2`=0.
- **Reset mid-operation:** assert `rst_n`=0 with 3 entries queued. Required: next cycle `write_back`=0, `hit1`=`hit2`=0, and no stale entries retire after release.
